// File: rtl/mcu_pkg.sv
// Shared definitions for the control unit and its memory-side responder:
// FSM encoding, default bus widths and request opcodes.
package mcu_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 8;
   localparam int unsigned DEF_DATA_WIDTH = 8;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/ram_array.sv
// Synchronous single-port RAM with registered read data. Accesses beyond
// DEPTH are ignored for writes and return zero for reads.
module ram_array
   import mcu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH      = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   localparam int unsigned         IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] dout_d, dout_q;
   logic                  in_range;
   logic [IW-1:0]         idx;

   assign in_range = ({1'b0, addr} < LIMIT);
   assign idx      = addr[IW-1:0];

   always_ff @(posedge clk) begin
      if (we && in_range) begin
         mem_q[idx] <= din;
      end
   end

   always_comb begin
      dout_d = dout_q;
      if (re) begin
         dout_d = in_range ? mem_q[idx] : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder: accepts held read/write requests, inserts
// WAIT_STATES wait cycles, then pulses ready (and err for illegal requests).
module ram_responder
   import mcu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ram_read_enable,
   input  logic                  ram_write_enable,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ready,
   output logic                  err,
   output logic                  busy
);

   localparam logic [3:0]          WS_LOAD = 4'(WAIT_STATES);
   localparam logic [ADDR_WIDTH:0] LIMIT   = (ADDR_WIDTH + 1)'(DEPTH);

   state_e                state_d, state_q;
   logic [3:0]            cnt_d, cnt_q;
   logic                  op_d, op_q;
   logic                  illegal_d, illegal_q;
   logic [ADDR_WIDTH-1:0] addr_d, addr_q;
   logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
   logic                  mem_go, op_en, addr_ok;

   assign op_en   = (op_q == OP_WRITE) ? ram_write_enable : ram_read_enable;
   assign addr_ok = ({1'b0, addr_q} < LIMIT);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      illegal_d = illegal_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      mem_go    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (ram_read_enable ^ ram_write_enable) begin
               op_d      = ram_write_enable ? OP_WRITE : OP_READ;
               addr_d    = addr;
               wdata_d   = wdata;
               illegal_d = 1'b0;
               cnt_d     = WS_LOAD;
               if (WAIT_STATES == 0) begin
                  state_d = ST_DONE;
                  mem_go  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
               end
            end else if (ram_read_enable && ram_write_enable) begin
               illegal_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_WAIT: begin
            if (!op_en) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = ST_DONE;
                  mem_go  = 1'b1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= OP_READ;
         illegal_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         illegal_q <= illegal_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
      end
   end

   // The RAM is accessed on the edge entering DONE so read data is already
   // registered while ready is high; next-state operands cover WAIT_STATES=0.
   ram_array #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
   ) u_ram (
      .clk  (clk),
      .rst_n(reset),
      .we   (mem_go && (op_d == OP_WRITE)),
      .re   (mem_go && (op_d == OP_READ)),
      .addr (addr_d),
      .din  (wdata_d),
      .dout (rdata)
   );

   assign ready = (state_q == ST_DONE);
   assign err   = (state_q == ST_DONE) && (illegal_q || !addr_ok);
   assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: four instances with different wait-state/depth
// settings, table vectors, hand-written corner sequences and random traffic.
module tb_ram_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic       rd_s    [4];
   logic       wr_s    [4];
   logic [7:0] addr_s  [4];
   logic [7:0] wdata_s [4];
   logic [7:0] rdata_s [4];
   logic       ready_s [4];
   logic       err_s   [4];
   logic       busy_s  [4];

   int total = 0;
   int bad   = 0;

   int         ws_m    [4];
   int         depth_m [4];
   logic [7:0] mem_m   [4][256];
   bit         known_m [4][256];
   logic [7:0] last_m  [4];
   bit         lastk_m [4];

   always #5 clk = ~clk;

   ram_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset), .ram_read_enable(rd_s[0]), .ram_write_enable(wr_s[0]),
      .addr(addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]),
      .err(err_s[0]), .busy(busy_s[0]));
   ram_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256), .WAIT_STATES(1)) dut1 (
      .clk(clk), .reset(reset), .ram_read_enable(rd_s[1]), .ram_write_enable(wr_s[1]),
      .addr(addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]),
      .err(err_s[1]), .busy(busy_s[1]));
   ram_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(128), .WAIT_STATES(2)) dut2 (
      .clk(clk), .reset(reset), .ram_read_enable(rd_s[2]), .ram_write_enable(wr_s[2]),
      .addr(addr_s[2]), .wdata(wdata_s[2]), .rdata(rdata_s[2]), .ready(ready_s[2]),
      .err(err_s[2]), .busy(busy_s[2]));
   ram_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256), .WAIT_STATES(3)) dut3 (
      .clk(clk), .reset(reset), .ram_read_enable(rd_s[3]), .ram_write_enable(wr_s[3]),
      .addr(addr_s[3]), .wdata(wdata_s[3]), .rdata(rdata_s[3]), .ready(ready_s[3]),
      .err(err_s[3]), .busy(busy_s[3]));

   typedef struct {
      int         k;
      bit         r;
      bit         w;
      logic [7:0] a;
      logic [7:0] d;
      int         lat;
      bit         er;
      logic [7:0] rd;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Issue one request, hold it until ready, drop it for a cycle afterwards.
   task automatic do_req(input int k, input bit r, input bit w, input logic [7:0] a,
                         input logic [7:0] d, output int lat, output int bcyc,
                         output logic [7:0] rd_o, output logic er_o);
      bit got;
      got = 1'b0;
      @(negedge clk);
      rd_s[k] = r; wr_s[k] = w; addr_s[k] = a; wdata_s[k] = d;
      lat = 0; bcyc = 0; rd_o = '0; er_o = 1'b0;
      while (!got && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (busy_s[k]) bcyc++;
         if (ready_s[k]) begin
            got  = 1'b1;
            rd_o = rdata_s[k];
            er_o = err_s[k];
         end
      end
      if (!got) chk("ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      rd_s[k] = 1'b0; wr_s[k] = 1'b0;
      @(posedge clk); #1;
      chk("no_spurious_ready", 32'(ready_s[k]), 32'd0);
      chk("idle_after_done", 32'(busy_s[k]), 32'd0);
   endtask

   task automatic check_txn(input int k, input bit r, input bit w, input logic [7:0] a,
                            input logic [7:0] d, input int e_lat, input bit e_err,
                            input logic [7:0] e_rd, input bit chk_rd, input string tag);
      int lat, bcyc;
      logic [7:0] rdv;
      logic erv;
      do_req(k, r, w, a, d, lat, bcyc, rdv, erv);
      chk({tag, "_latency"}, lat, e_lat);
      chk({tag, "_busy_cycles"}, bcyc, e_lat);
      chk({tag, "_err"}, 32'(erv), 32'(e_err));
      if (chk_rd) chk({tag, "_rdata"}, 32'(rdv), 32'(e_rd));
   endtask

   function automatic void model_exp(input int k, input bit r, input bit w, input logic [7:0] a,
                                     output int lat, output bit er, output logic [7:0] rdv,
                                     output bit rdk);
      bit inr;
      inr = int'(a) < depth_m[k];
      lat = (r && w) ? 1 : ws_m[k] + 1;
      er  = (r && w) || !inr;
      if (r && !w) begin
         rdv = inr ? mem_m[k][a] : 8'h00;
         rdk = inr ? known_m[k][a] : 1'b1;
      end else begin
         rdv = last_m[k];
         rdk = lastk_m[k];
      end
   endfunction

   function automatic void model_apply(input int k, input bit r, input bit w,
                                       input logic [7:0] a, input logic [7:0] d);
      int lat;
      bit er, rdk;
      logic [7:0] rdv;
      model_exp(k, r, w, a, lat, er, rdv, rdk);
      if (w && !r && int'(a) < depth_m[k]) begin
         mem_m[k][a]   = d;
         known_m[k][a] = 1'b1;
      end
      last_m[k]  = rdv;
      lastk_m[k] = rdk;
   endfunction

   task automatic run_model(input int k, input bit r, input bit w, input logic [7:0] a,
                            input logic [7:0] d, input string tag);
      int lat;
      bit er, rdk;
      logic [7:0] rdv;
      model_exp(k, r, w, a, lat, er, rdv, rdk);
      check_txn(k, r, w, a, d, lat, er, rdv, rdk, tag);
      model_apply(k, r, w, a, d);
   endtask

   initial begin
      int k, sel;
      bit r, w;
      logic [7:0] a, d;

      ws_m    = '{0, 1, 2, 3};
      depth_m = '{256, 256, 128, 256};
      for (int i = 0; i < 4; i++) begin
         rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0;
         last_m[i] = 8'h00; lastk_m[i] = 1'b1;
         for (int j = 0; j < 256; j++) begin
            known_m[i][j] = 1'b0;
            mem_m[i][j]   = 8'h00;
         end
      end

      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("reset_ready", 32'(ready_s[i]), 32'd0);
         chk("reset_err", 32'(err_s[i]), 32'd0);
         chk("reset_busy", 32'(busy_s[i]), 32'd0);
         chk("reset_rdata", 32'(rdata_s[i]), 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;

      //        k  r  w  addr   data   lat err rdata
      vt.push_back('{1, 0, 1, 8'h20, 8'hA5, 2, 0, 8'h00});
      vt.push_back('{1, 1, 0, 8'h20, 8'h00, 2, 0, 8'hA5});
      vt.push_back('{1, 0, 1, 8'h05, 8'h11, 2, 0, 8'hA5});
      vt.push_back('{1, 1, 1, 8'h05, 8'hFF, 1, 1, 8'hA5});
      vt.push_back('{1, 1, 0, 8'h05, 8'h00, 2, 0, 8'h11});
      vt.push_back('{0, 0, 1, 8'h20, 8'h5A, 1, 0, 8'h00});
      vt.push_back('{0, 1, 0, 8'h20, 8'h00, 1, 0, 8'h5A});
      vt.push_back('{3, 0, 1, 8'h10, 8'h42, 4, 0, 8'h00});
      vt.push_back('{3, 1, 0, 8'h10, 8'h00, 4, 0, 8'h42});
      vt.push_back('{2, 0, 1, 8'h10, 8'h77, 3, 0, 8'h00});
      vt.push_back('{2, 1, 0, 8'h10, 8'h00, 3, 0, 8'h77});
      vt.push_back('{2, 0, 1, 8'h90, 8'h3C, 3, 1, 8'h77});
      vt.push_back('{2, 1, 0, 8'h90, 8'h00, 3, 1, 8'h00});
      vt.push_back('{2, 1, 0, 8'h10, 8'h00, 3, 0, 8'h77});
      vt.push_back('{2, 0, 1, 8'h7F, 8'h7E, 3, 0, 8'h77});
      vt.push_back('{2, 1, 0, 8'h7F, 8'h00, 3, 0, 8'h7E});
      vt.push_back('{2, 0, 1, 8'h80, 8'h81, 3, 1, 8'h7E});
      vt.push_back('{2, 0, 1, 8'h01, 8'h61, 3, 0, 8'h7E});
      vt.push_back('{2, 0, 1, 8'h02, 8'h62, 3, 0, 8'h7E});
      vt.push_back('{2, 0, 1, 8'h30, 8'h33, 3, 0, 8'h7E});
      foreach (vt[i]) begin
         check_txn(vt[i].k, vt[i].r, vt[i].w, vt[i].a, vt[i].d, vt[i].lat, vt[i].er,
                   vt[i].rd, 1'b1, $sformatf("vec%0d", i));
         model_apply(vt[i].k, vt[i].r, vt[i].w, vt[i].a, vt[i].d);
      end

      // Reset asserted while a write to 0x10 is still waiting.
      @(negedge clk);
      wr_s[3] = 1'b1; addr_s[3] = 8'h10; wdata_s[3] = 8'h99;
      repeat (2) @(posedge clk);
      #1;
      chk("midwait_busy", 32'(busy_s[3]), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_async_busy", 32'(busy_s[3]), 32'd0);
      chk("rst_async_ready", 32'(ready_s[3]), 32'd0);
      chk("rst_async_err", 32'(err_s[3]), 32'd0);
      chk("rst_async_rdata3", 32'(rdata_s[3]), 32'd0);
      chk("rst_async_rdata1", 32'(rdata_s[1]), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      wr_s[3] = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         last_m[i] = 8'h00; lastk_m[i] = 1'b1;
      end
      run_model(3, 1'b1, 1'b0, 8'h10, 8'h00, "post_reset_read");

      // Write aborted during WAIT must leave no trace.
      @(negedge clk);
      wr_s[2] = 1'b1; addr_s[2] = 8'h30; wdata_s[2] = 8'hEE;
      @(posedge clk); #1;
      chk("abort_wait_busy", 32'(busy_s[2]), 32'd1);
      chk("abort_wait_ready", 32'(ready_s[2]), 32'd0);
      @(negedge clk);
      wr_s[2] = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy_low", 32'(busy_s[2]), 32'd0);
      chk("abort_no_ready", 32'(ready_s[2]), 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("abort_quiet", 32'(ready_s[2]), 32'd0);
      end
      run_model(2, 1'b1, 1'b0, 8'h30, 8'h00, "abort_readback");
      run_model(2, 1'b1, 1'b0, 8'h01, 8'h00, "b2b_first");
      run_model(2, 1'b1, 1'b0, 8'h02, 8'h00, "b2b_second");

      for (int i = 0; i < 150; i++) begin
         k   = ($urandom_range(0, 1) == 0) ? 1 : 2;
         sel = $urandom_range(0, 9);
         r   = (sel == 0) || (sel >= 5);
         w   = (sel < 5);
         a   = 8'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) a = a | 8'h80;
         d   = 8'($urandom);
         run_model(k, r, w, a, d, $sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
